// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: state encodings and default addresses.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_BOOT = 2'b00,
        SEQ_RUN  = 2'b01,
        SEQ_HOLD = 2'b10,
        SEQ_HALT = 2'b11
    } seq_state_e;

    localparam logic [31:0] RESET_PC_DEF    = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEF  = 32'h0000_4180;
    localparam logic [31:0] MAX_INSADDR_DEF = 32'hffff_fff8;

    // Fetch addresses are word aligned; low target bits are simply dropped.
    function automatic logic [31:0] align4(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the sequencer and its neighbours (hazard unit, exception logic, jump controller).
// Latency: n/a (wiring only).
// Backpressure: stall is carried here and forwarded to the jump controller as jc_stall.
interface pc_sequencer_if;
    logic        stall;
    logic [31:0] ctrl_npc;
    logic        ctrl_clr;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic        halt_req;
    logic [31:0] pc;
    logic        if_valid;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        jc_stall;
    logic [1:0]  seq_state;
    logic        pc_overflow;
    logic [31:0] redirect_cnt;
    logic [31:0] stall_cnt;

    // Requesters side: drives redirect/stall requests, observes the fetch PC.
    modport master (
        output stall, ctrl_npc, ctrl_clr, exc_req, eret_req, epc, halt_req,
        input  pc, if_valid, flush_if_id, flush_id_ex, jc_stall, seq_state,
               pc_overflow, redirect_cnt, stall_cnt
    );

    // Sequencer side.
    modport slave (
        input  stall, ctrl_npc, ctrl_clr, exc_req, eret_req, epc, halt_req,
        output pc, if_valid, flush_if_id, flush_id_ex, jc_stall, seq_state,
               pc_overflow, redirect_cnt, stall_cnt
    );
endinterface

// File: rtl/pc_sequencer_perf.sv
// Saturating redirect / stall-cycle counters; only built when PC_SEQ_PERF_EN is defined.
// Latency: count visible one clock after the counted cycle.
// Backpressure: none; counters saturate at all-ones instead of wrapping.
`ifdef PC_SEQ_PERF_EN
module pc_seq_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic        stall_i,
    output logic [31:0] redirect_cnt_o,
    output logic [31:0] stall_cnt_o
);
    logic [31:0] redirect_cnt_q;
    logic [31:0] stall_cnt_q;

    // Count qualified events, holding at the maximum value once reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            if (redirect_i && (redirect_cnt_q != 32'hffff_ffff))
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            if (stall_i && (stall_cnt_q != 32'hffff_ffff))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign redirect_cnt_o = redirect_cnt_q;
    assign stall_cnt_o    = stall_cnt_q;
endmodule
`endif

// File: rtl/pc_sequencer.sv
// PC register and fetch sequencer: arbitrates halt > exception > eret > redirect > stall > fetch.
// Latency: accepted request to new pc = 1 clock; flushes asserted combinationally in the request cycle.
// Backpressure: a redirect under stall is parked (first wins) until stall drops. Macro PC_SEQ_PERF_EN adds perf counters.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF,
    parameter logic [31:0] MAX_INSADDR = MAX_INSADDR_DEF
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);
    seq_state_e  state_q;
    logic [31:0] pc_q;
    logic [31:0] pend_addr_q;
    logic        pend_valid_q;
    logic        ovf_q;

    logic in_run, in_hold, active;
    logic take_halt, take_exc, take_eret, take_redir, take_defer, take_pend;
    logic seq_fetch, wrap;

    // Decode which single request is accepted this cycle, in priority order.
    always_comb begin
        in_run     = (state_q == SEQ_RUN);
        in_hold    = (state_q == SEQ_HOLD);
        active     = in_run | in_hold;
        take_halt  = active & bus.halt_req;
        take_exc   = active & ~bus.halt_req & bus.exc_req;
        take_eret  = active & ~bus.halt_req & ~bus.exc_req & bus.eret_req;
        take_redir = in_run & ~bus.halt_req & ~bus.exc_req & ~bus.eret_req
                   & bus.ctrl_clr & ~bus.stall;
        take_defer = in_run & ~bus.halt_req & ~bus.exc_req & ~bus.eret_req
                   & bus.ctrl_clr & bus.stall;
        take_pend  = in_hold & pend_valid_q & ~bus.halt_req & ~bus.exc_req
                   & ~bus.eret_req & ~bus.stall;
        seq_fetch  = in_run & ~bus.halt_req & ~bus.exc_req & ~bus.eret_req
                   & ~bus.ctrl_clr & ~bus.stall;
        // Sequential step past the last legal address ends the program instead of wrapping.
        wrap       = seq_fetch & (pc_q >= MAX_INSADDR)
                   & (align4(bus.ctrl_npc) == pc_q + 32'd4);
    end

    // Sequencer FSM and PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SEQ_BOOT;
            pc_q         <= align4(RESET_PC);
            pend_addr_q  <= '0;
            pend_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else if (state_q == SEQ_BOOT) begin
            state_q <= SEQ_RUN;
        end else if (take_halt) begin
            state_q <= SEQ_HALT;
        end else if (take_exc || take_eret) begin
            pc_q         <= take_exc ? align4(EXC_VECTOR) : align4(bus.epc);
            pend_valid_q <= 1'b0;
            state_q      <= SEQ_RUN;
        end else if (take_redir) begin
            pc_q <= align4(bus.ctrl_npc);
        end else if (take_defer) begin
            pend_addr_q  <= align4(bus.ctrl_npc);
            pend_valid_q <= 1'b1;
            state_q      <= SEQ_HOLD;
        end else if (take_pend) begin
            pc_q         <= pend_addr_q;
            pend_valid_q <= 1'b0;
            state_q      <= SEQ_RUN;
        end else if (wrap) begin
            ovf_q   <= 1'b1;
            state_q <= SEQ_HALT;
        end else if (seq_fetch) begin
            pc_q <= align4(bus.ctrl_npc);
        end
    end

    assign bus.pc          = pc_q;
    assign bus.if_valid    = active;
    assign bus.flush_if_id = take_exc | take_eret | take_redir | take_pend;
    assign bus.flush_id_ex = take_exc | take_eret;
    assign bus.jc_stall    = bus.stall | ~in_run;
    assign bus.seq_state   = state_q;
    assign bus.pc_overflow = ovf_q;

`ifdef PC_SEQ_PERF_EN
    pc_seq_perf u_perf (
        .clk            (clk),
        .rst            (rst),
        .redirect_i     (bus.flush_if_id),
        .stall_i        (bus.jc_stall & active),
        .redirect_cnt_o (bus.redirect_cnt),
        .stall_cnt_o    (bus.stall_cnt)
    );
`else
    assign bus.redirect_cnt = '0;
    assign bus.stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a per-cycle behavioural model and literal spot checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    pc_sequencer_if bus();

    pc_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_boot, m_halt, m_ovf, m_valid;
    logic [31:0] m_pc;
    logic [31:0] pendq[$];
    int unsigned m_redir, m_stall;

    initial begin
        m_valid = 0;
        forever begin
            logic [31:0] tgt;
            bit fif, fex, act, hold, jcs;
            logic [1:0] st;
            @(negedge clk);
            act  = !m_boot && !m_halt;
            hold = act && (pendq.size() > 0);
            st   = m_boot ? 2'b00 : m_halt ? 2'b11 : hold ? 2'b10 : 2'b01;
            jcs  = bus.stall || !(act && !hold);
            fif = 0; fex = 0;
            tgt = bus.ctrl_npc & 32'hffff_fffc;
            if (rst) begin
                m_boot = 1; m_halt = 0; m_ovf = 0; m_pc = 32'h0000_3000;
                pendq.delete(); m_redir = 0; m_stall = 0;
            end else if (m_valid) begin
                check("pc", bus.pc, m_pc);
                check("state", {30'd0, bus.seq_state}, {30'd0, st});
                check("if_valid", {31'd0, bus.if_valid}, {31'd0, act});
                check("jc_stall", {31'd0, bus.jc_stall}, {31'd0, jcs});
                check("ovf", {31'd0, bus.pc_overflow}, {31'd0, m_ovf});
`ifdef PC_SEQ_PERF_EN
                check("redirect_cnt", bus.redirect_cnt, m_redir);
                check("stall_cnt", bus.stall_cnt, m_stall);
`else
                check("redirect_cnt", bus.redirect_cnt, 32'd0);
                check("stall_cnt", bus.stall_cnt, 32'd0);
`endif
                if (m_boot) m_boot = 0;
                else if (m_halt) ;
                else if (bus.halt_req) m_halt = 1;
                else if (bus.exc_req) begin
                    m_pc = 32'h0000_4180; fif = 1; fex = 1; pendq.delete();
                end else if (bus.eret_req) begin
                    m_pc = bus.epc & 32'hffff_fffc; fif = 1; fex = 1; pendq.delete();
                end else if (pendq.size() > 0) begin
                    if (!bus.stall) begin m_pc = pendq.pop_front(); fif = 1; end
                end else if (bus.ctrl_clr) begin
                    if (bus.stall) pendq.push_back(tgt);
                    else begin m_pc = tgt; fif = 1; end
                end else if (bus.stall) ;
                else if (m_pc >= 32'hffff_fff8 && tgt == m_pc + 32'd4) begin
                    m_halt = 1; m_ovf = 1;
                end else m_pc = tgt;
                check("flush_if_id", {31'd0, bus.flush_if_id}, {31'd0, fif});
                check("flush_id_ex", {31'd0, bus.flush_id_ex}, {31'd0, fex});
                if (fif) m_redir++;
                if (jcs && act) m_stall++;
            end
            if (rst) m_valid = 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall = 0; bus.ctrl_clr = 0; bus.exc_req = 0;
        bus.eret_req = 0; bus.halt_req = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        bus.ctrl_npc = 32'h0000_3004;
        bus.epc = 32'h0;
        rst = 1;
        step(); step();
        rst = 0;
        // Reset state: BOOT, pc at reset vector, nothing valid.
        check("lit_rst_pc", bus.pc, 32'h0000_3000);
        check("lit_rst_valid", {31'd0, bus.if_valid}, 32'd0);
        check("lit_rst_state", {30'd0, bus.seq_state}, 32'd0);
        step();
        check("lit_run_state", {30'd0, bus.seq_state}, 32'd1);
        check("lit_run_valid", {31'd0, bus.if_valid}, 32'd1);
        check("lit_run_pc", bus.pc, 32'h0000_3000);
        step();
        check("lit_seq1", bus.pc, 32'h0000_3004);
        bus.ctrl_npc = 32'h0000_3008;
        step();
        check("lit_seq2", bus.pc, 32'h0000_3008);

        // Redirect under stall parks in HOLD until stall drops.
        bus.stall = 1; bus.ctrl_clr = 1; bus.ctrl_npc = 32'h0000_3040;
        step();
        bus.ctrl_clr = 0; bus.ctrl_npc = 32'h0000_300c;
        check("lit_hold_state", {30'd0, bus.seq_state}, 32'd2);
        step(); step();
        check("lit_hold_pc", bus.pc, 32'h0000_3008);
        bus.stall = 0;
        #1;
        check("lit_pend_flush", {31'd0, bus.flush_if_id}, 32'd1);
        step();
        check("lit_pend_pc", bus.pc, 32'h0000_3040);

        // Exception while parked discards the pending target.
        bus.ctrl_npc = 32'h0000_3044;
        step();
        bus.stall = 1; bus.ctrl_clr = 1; bus.ctrl_npc = 32'h0000_3080;
        step();
        bus.ctrl_clr = 0; bus.exc_req = 1;
        #1;
        check("lit_exc_flush", {31'd0, bus.flush_id_ex}, 32'd1);
        step();
        idle();
        check("lit_exc_pc", bus.pc, 32'h0000_4180);
        bus.ctrl_npc = 32'h0000_4184;
        step();
        check("lit_exc_seq", bus.pc, 32'h0000_4184);
        bus.eret_req = 1; bus.epc = 32'h0000_3013;
        step();
        idle();
        check("lit_eret_pc", bus.pc, 32'h0000_3010);

        // Sequential fetch past the last legal address halts.
        bus.ctrl_clr = 1; bus.ctrl_npc = 32'hffff_fff8;
        step();
        bus.ctrl_clr = 0; bus.ctrl_npc = 32'hffff_fffc;
        check("lit_top_pc", bus.pc, 32'hffff_fff8);
        step();
        check("lit_halt_state", {30'd0, bus.seq_state}, 32'd3);
        check("lit_halt_ovf", {31'd0, bus.pc_overflow}, 32'd1);
        check("lit_halt_valid", {31'd0, bus.if_valid}, 32'd0);
        bus.exc_req = 1;
        step();
        bus.exc_req = 0;
        check("lit_halt_exc", bus.pc, 32'hffff_fff8);
        rst = 1;
        step();
        rst = 0;
        check("lit_recover_pc", bus.pc, 32'h0000_3000);
        check("lit_recover_ovf", {31'd0, bus.pc_overflow}, 32'd0);

        // Counter scenario: 5 redirects then 7 stall cycles in RUN.
        bus.ctrl_npc = 32'h0000_3100;
        step();
        for (int i = 0; i < 5; i++) begin
            bus.ctrl_clr = 1; bus.ctrl_npc = 32'h0000_3100 + 32'(i * 16);
            step();
        end
        bus.ctrl_clr = 0;
        bus.stall = 1;
        for (int i = 0; i < 7; i++) step();
        bus.stall = 0; bus.ctrl_npc = 32'h0000_3200;
        step();
        step();
`ifdef PC_SEQ_PERF_EN
        check("lit_redirect_cnt", bus.redirect_cnt, 32'd5);
        check("lit_stall_cnt", bus.stall_cnt, 32'd7);
`else
        check("lit_redirect_cnt", bus.redirect_cnt, 32'd0);
        check("lit_stall_cnt", bus.stall_cnt, 32'd0);
`endif
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
